// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and combine operator for the 2x2 pooling engine
package pool_pkg;

    // Wide enough for any DATA_W up to OP_W-2 plus the two-bit window sum growth
    localparam int OP_W = 33;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pool_state_e;

    function automatic logic signed [OP_W-1:0] pool_op(
        input logic signed [OP_W-1:0] a,
        input logic signed [OP_W-1:0] b,
        input pool_mode_e             mode
    );
        if (mode == POOL_MAX) begin
            return (a > b) ? a : b;
        end
        return a + b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - one-row store of horizontal partial results, all channels side by side
module pool_line_buffer #(
    parameter int CH    = 4,
    parameter int W     = 17,
    parameter int DEPTH = 14,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [CH*W-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [CH*W-1:0] o_rdata
);

    logic [CH*W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool2x2_stream_unit.sv
// rtl/pool2x2_stream_unit.sv - streaming 2x2 stride-2 max/average pooling with valid/ready on both sides
module pool2x2_stream_unit
    import pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CH     = 4,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int BUF_AW = $clog2(IMG_W/2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 in_valid,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [CH*DATA_W-1:0] out_data,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int HW = DATA_W + 1;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = (BUF_AW > 0) ? BUF_AW : 1;

    if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2 || CH < 1 || DATA_W > OP_W - 2)
    begin : g_param_check
        $error("pool2x2_stream_unit: IMG_W/IMG_H must be even and >= 2, CH >= 1, DATA_W <= OP_W-2");
    end

    pool_state_e          r_state, w_next;
    pool_mode_e           r_mode;
    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic [CH*HW-1:0]     r_h;
    logic [CH*DATA_W-1:0] r_out;
    logic                 r_out_valid, r_out_last;

    logic                 w_accept, w_col_last, w_row_last, w_lb_we;
    logic [AW-1:0]        w_addr;
    logic [CH*HW-1:0]     w_pix_ext, w_lb_wdata, w_lb_rdata;
    logic [CH*DATA_W-1:0] w_win;

    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_addr     = AW'(r_col >> 1);
    assign w_lb_we    = w_accept && r_col[0] && !r_row[0];

    pool_line_buffer #(
        .CH(CH), .W(HW), .DEPTH(IMG_W/2), .AW(AW)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_waddr (w_addr),
        .i_wdata (w_lb_wdata),
        .i_raddr (w_addr),
        .o_rdata (w_lb_rdata)
    );

    // Horizontal pair is combined first; odd rows then fold in the stored upper pair
    always_comb begin
        logic signed [OP_W-1:0] v_pix, v_h, v_lb, v_sum;
        w_pix_ext  = '0;
        w_lb_wdata = '0;
        w_win      = '0;
        v_pix      = '0;
        v_h        = '0;
        v_lb       = '0;
        v_sum      = '0;
        for (int c = 0; c < CH; c++) begin
            v_pix = OP_W'($signed(in_data[c*DATA_W +: DATA_W]));
            v_h   = pool_op(OP_W'($signed(r_h[c*HW +: HW])), v_pix, r_mode);
            v_lb  = OP_W'($signed(w_lb_rdata[c*HW +: HW]));
            v_sum = pool_op(v_lb, v_h, r_mode);
            w_pix_ext[c*HW +: HW]  = v_pix[HW-1:0];
            w_lb_wdata[c*HW +: HW] = v_h[HW-1:0];
            w_win[c*DATA_W +: DATA_W] = (r_mode == POOL_AVG) ? DATA_W'(v_sum >>> 2)
                                                             : v_sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_accept && w_col_last && w_row_last) w_next = DRAIN;
            DRAIN:   if (r_out_valid && out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != IDLE);
        in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
        done     = (r_state == DRAIN) && r_out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_h         <= '0;
            r_mode      <= POOL_MAX;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_col  <= '0;
                r_row  <= '0;
                r_mode <= pool_mode_e'(mode);
            end
            if (w_accept) begin
                if (!r_col[0]) begin
                    r_h <= w_pix_ext;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_accept && r_col[0] && r_row[0]) begin
                r_out       <= w_win;
                r_out_valid <= 1'b1;
                r_out_last  <= w_col_last && w_row_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign out_last  = r_out_last;

endmodule
